ped_signal_ctrl: RTL

Pedestrian-crossing stage that sits directly downstream of the vehicle traffic-light controller. It consumes that controller's three lamp outputs, latches pedestrian button requests, and drives the WALK / DONT_WALK heads with a walk interval, a flashing clearance interval and a countdown display. The walk is granted only inside a vehicle-red phase. Any lamp inconsistency or early loss of red forces DONT_WALK.

---
 rtl/ped_signal_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ped_signal_ctrl.sv
// rtl/ped_signal_ctrl.sv - pedestrian WALK/DONT_WALK controller slaved to the vehicle signal lamps
//
// Purpose: latches pedestrian requests, grants a walk interval followed by a
// flashing clearance interval inside a vehicle-red phase, and drives a countdown.
// Any lamp conflict latches a sticky fault with solid DONT_WALK.
//
// Optional feature macro: PED_CHIRP_EN (adds the 'chirp' audible-cue output).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tick              single-cycle time-base enable
//   t_red/t_yel/t_grn vehicle lamps from the upstream controller
//   ped_btn           raw asynchronous pedestrian button
//   walk, dont_walk   pedestrian heads (dont_walk flashes during clearance)
//   countdown         remaining ticks of WALK/FLASH, 0 otherwise
//   req_pending       request latched, not yet served
//   abort             one-cycle pulse when red drops during WALK/FLASH
//   fault             sticky lamp-conflict flag
//   chirp             (PED_CHIRP_EN only) toggles on each tick while in WALK
module ped_signal_ctrl #(
  parameter int WALK_TICKS  = 10,
  parameter int CLEAR_TICKS = 15,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          t_red,
  input  logic          t_yel,
  input  logic          t_grn,
  input  logic          ped_btn,
  output logic          walk,
  output logic          dont_walk,
  output logic [CW-1:0] countdown,
  output logic          req_pending,
  output logic          abort,
`ifdef PED_CHIRP_EN
  output logic          chirp,
`endif
  output logic          fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RED, S_WALK, S_FLASH, S_HOLD, S_FAULT
  } state_t;

  localparam logic [CW-1:0] WALK_CD  = CW'(WALK_TICKS);
  localparam logic [CW-1:0] CLEAR_CD = CW'(CLEAR_TICKS);

  state_t        r_state;
  logic          r1_red, r1_yel, r1_grn, r2_red;
  logic          r_btn_s1, r_btn_s2, r_btn_s3;
  logic          r_walk, r_dont_walk, r_req, r_abort, r_fault;
  logic [CW-1:0] r_countdown;

  logic w_red_rise, w_lamp_conflict, w_btn_edge, w_cd_last;

  assign w_red_rise      = r1_red & ~r2_red;
  // All lamps dark is legal (upstream in reset); two or more lit is not.
  assign w_lamp_conflict = (r1_red & r1_yel) | (r1_red & r1_grn) | (r1_yel & r1_grn);
  assign w_btn_edge      = r_btn_s2 & ~r_btn_s3;
  assign w_cd_last       = (r_countdown == CW'(1));

  assign walk        = r_walk;
  assign dont_walk   = r_dont_walk;
  assign countdown   = r_countdown;
  assign req_pending = r_req;
  assign abort       = r_abort;
  assign fault       = r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r1_red      <= 1'b0;
      r1_yel      <= 1'b0;
      r1_grn      <= 1'b0;
      r2_red      <= 1'b0;
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
      r_btn_s3    <= 1'b0;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_countdown <= '0;
      r_req       <= 1'b0;
      r_abort     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r1_red   <= t_red;
      r1_yel   <= t_yel;
      r1_grn   <= t_grn;
      r2_red   <= r1_red;
      r_btn_s1 <= ped_btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
      r_abort  <= 1'b0;

      // Presses during WALK are dropped: the crossing is already being served.
      if (w_btn_edge && r_state != S_WALK) r_req <= 1'b1;

      if (w_lamp_conflict || r_state == S_FAULT) begin
        r_state     <= S_FAULT;
        r_walk      <= 1'b0;
        r_dont_walk <= 1'b1;
        r_countdown <= '0;
        r_fault     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (r_req) r_state <= S_WAIT_RED;
          // Only a fresh red onset grants; a red already lit on entry is too
          // far into its phase to fit a full walk plus clearance.
          S_WAIT_RED: if (w_red_rise) begin
            r_state     <= S_WALK;
            r_walk      <= 1'b1;
            r_dont_walk <= 1'b0;
            r_countdown <= WALK_CD;
            r_req       <= 1'b0;
          end
          S_WALK, S_FLASH: begin
            // Early red loss outranks any tick arriving in the same cycle.
            if (!r1_red) begin
              r_state     <= r_req ? S_WAIT_RED : S_IDLE;
              r_walk      <= 1'b0;
              r_dont_walk <= 1'b1;
              r_countdown <= '0;
              r_abort     <= 1'b1;
            end else if (tick) begin
              if (w_cd_last) begin
                r_walk      <= 1'b0;
                r_dont_walk <= 1'b1;
                if (r_state == S_WALK) begin
                  r_state     <= S_FLASH;
                  r_countdown <= CLEAR_CD;
                end else begin
                  r_state     <= S_HOLD;
                  r_countdown <= '0;
                end
              end else begin
                if (r_countdown != '0) r_countdown <= r_countdown - CW'(1);
                if (r_state == S_FLASH) r_dont_walk <= ~r_dont_walk;
              end
            end
          end
          S_HOLD: if (!r1_red) r_state <= r_req ? S_WAIT_RED : S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PED_CHIRP_EN
  logic r_chirp;
  logic w_walk_stays;

  // True when the FSM remains in WALK through this edge.
  assign w_walk_stays = (r_state == S_WALK) && r1_red && !w_lamp_conflict &&
                        !(tick && w_cd_last);

  always_ff @(posedge clk) begin
    if (rst) r_chirp <= 1'b0;
    else     r_chirp <= w_walk_stays ? (r_chirp ^ tick) : 1'b0;
  end

  assign chirp = r_chirp;
`endif

  always_ff @(posedge clk) begin
    if (!rst) assert (!(r_walk && r_dont_walk));
  end

endmodule
